// File: rtl/mips32_id_stage.sv
// rtl/mips32_id_stage.sv - MIPS32 instruction decode stage with register bank and ID/EX latch
module mips32_id_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk1,
   input  logic            rst,
   input  logic            if_id_valid,
   output logic            if_id_ready,
   input  logic [31:0]     if_id_ir,
   input  logic [31:0]     if_id_npc,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_ex_valid,
   input  logic            id_ex_ready,
   output logic [31:0]     id_ex_ir,
   output logic [31:0]     id_ex_npc,
   output logic [XLEN-1:0] id_ex_a,
   output logic [XLEN-1:0] id_ex_b,
   output logic [31:0]     id_ex_imm,
   output logic [2:0]      id_ex_type,
   output logic            id_ex_illegal,
   output logic            halted
);

   localparam logic [2:0] T_RR_ALU  = 3'b000;
   localparam logic [2:0] T_RM_ALU  = 3'b001;
   localparam logic [2:0] T_LOAD    = 3'b010;
   localparam logic [2:0] T_STORE   = 3'b011;
   localparam logic [2:0] T_BRANCH  = 3'b100;
   localparam logic [2:0] T_HALT    = 3'b101;
   localparam logic [2:0] T_ILLEGAL = 3'b111;

   logic [XLEN-1:0] regs [NREGS];

   logic [5:0]      opcode;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [2:0]      dec_type;
   logic            dec_illegal;
   logic [XLEN-1:0] rd_a;
   logic [XLEN-1:0] rd_b;
   logic            wb_live;
   logic            accept;

   assign opcode = if_id_ir[31:26];
   assign rs     = if_id_ir[25:21];
   assign rt     = if_id_ir[20:16];

   always_comb begin
      dec_type    = T_ILLEGAL;
      dec_illegal = 1'b1;
      case (opcode)
         6'b000000, 6'b000001, 6'b000010,
         6'b000011, 6'b000100, 6'b000101: begin dec_type = T_RR_ALU; dec_illegal = 1'b0; end
         6'b001010, 6'b001011, 6'b001100: begin dec_type = T_RM_ALU; dec_illegal = 1'b0; end
         6'b001000:                       begin dec_type = T_LOAD;   dec_illegal = 1'b0; end
         6'b001001:                       begin dec_type = T_STORE;  dec_illegal = 1'b0; end
         6'b001101, 6'b001110:            begin dec_type = T_BRANCH; dec_illegal = 1'b0; end
         6'b111111:                       begin dec_type = T_HALT;   dec_illegal = 1'b0; end
         default:                         begin dec_type = T_ILLEGAL; dec_illegal = 1'b1; end
      endcase
   end

   // A write-back landing this cycle is forwarded so decode never sees a stale register.
   assign wb_live = wb_we && (wb_rd != 5'd0);
   assign rd_a = (rs == 5'd0) ? '0 : ((wb_live && wb_rd == rs) ? wb_data : regs[rs]);
   assign rd_b = (rt == 5'd0) ? '0 : ((wb_live && wb_rd == rt) ? wb_data : regs[rt]);

   assign if_id_ready = !halted && (!id_ex_valid || id_ex_ready);
   assign accept      = if_id_valid && if_id_ready && !flush;

   always_ff @(posedge clk1) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         id_ex_valid   <= 1'b0;
         id_ex_ir      <= '0;
         id_ex_npc     <= '0;
         id_ex_a       <= '0;
         id_ex_b       <= '0;
         id_ex_imm     <= '0;
         id_ex_type    <= T_RR_ALU;
         id_ex_illegal <= 1'b0;
         halted        <= 1'b0;
      end else begin
         if (wb_live) begin
            regs[wb_rd] <= wb_data;
         end
         if (flush) begin
            id_ex_valid <= 1'b0;
         end else if (accept) begin
            id_ex_valid   <= 1'b1;
            id_ex_ir      <= if_id_ir;
            id_ex_npc     <= if_id_npc;
            id_ex_a       <= rd_a;
            id_ex_b       <= rd_b;
            id_ex_imm     <= {{16{if_id_ir[15]}}, if_id_ir[15:0]};
            id_ex_type    <= dec_type;
            id_ex_illegal <= dec_illegal;
            if (dec_type == T_HALT) begin
               halted <= 1'b1;
            end
         end else if (id_ex_ready) begin
            id_ex_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mips32_id_stage.sv
// tb/tb_mips32_id_stage.sv - scoreboard bench for mips32_id_stage
module tb_mips32_id_stage;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] npc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [2:0]  ty;
      logic        ill;
   } exp_t;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        if_id_valid;
   logic        if_id_ready;
   logic [31:0] if_id_ir;
   logic [31:0] if_id_npc;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        id_ex_valid;
   logic        id_ex_ready;
   logic [31:0] id_ex_ir;
   logic [31:0] id_ex_npc;
   logic [31:0] id_ex_a;
   logic [31:0] id_ex_b;
   logic [31:0] id_ex_imm;
   logic [2:0]  id_ex_type;
   logic        id_ex_illegal;
   logic        halted;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   n_push = 0;
   int   n_pop = 0;

   mips32_id_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk1(clk1), .rst(rst),
      .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
      .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .flush(flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_ex_valid(id_ex_valid), .id_ex_ready(id_ex_ready),
      .id_ex_ir(id_ex_ir), .id_ex_npc(id_ex_npc),
      .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm),
      .id_ex_type(id_ex_type), .id_ex_illegal(id_ex_illegal), .halted(halted)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
      else pass_cnt++;
   endtask

   function automatic exp_t mk(input logic [31:0] ir, input logic [31:0] npc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [2:0] ty, input logic ill);
      exp_t e;
      e.ir = ir; e.npc = npc; e.a = a; e.b = b; e.imm = imm; e.ty = ty; e.ill = ill;
      return e;
   endfunction

   // Drive one instruction from posedge+1 until accepted; push its expectation when it is.
   task automatic issue(input exp_t e, input bit push);
      bit done = 1'b0;
      if_id_valid = 1'b1;
      if_id_ir    = e.ir;
      if_id_npc   = e.npc;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk1);
         if (if_id_ready && !flush) begin
            done = 1'b1;
            if (push) begin
               sb.push_back(e);
               n_push++;
            end
         end
         @(posedge clk1); #1;
      end
      if (!done) begin
         total_cnt++;
         $display("FAIL issue_timeout: ir %h never accepted", e.ir);
      end
      if_id_valid = 1'b0;
   endtask

   always @(negedge clk1) begin
      if (!rst && id_ex_valid && id_ex_ready) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: got ir %h expected no entry", id_ex_ir);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_pop++;
            chk("out_ir", id_ex_ir, e.ir);
            chk("out_npc", id_ex_npc, e.npc);
            chk("out_a", id_ex_a, e.a);
            chk("out_b", id_ex_b, e.b);
            chk("out_imm", id_ex_imm, e.imm);
            chk("out_type", {29'd0, id_ex_type}, {29'd0, e.ty});
            chk("out_illegal", {31'd0, id_ex_illegal}, {31'd0, e.ill});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; if_id_valid = 1'b0; if_id_ir = '0; if_id_npc = '0; flush = 1'b0;
      id_ex_ready = 1'b0;
      wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_1234;
      repeat (2) @(posedge clk1);
      #1 wb_we = 1'b0;
      @(negedge clk1);
      chk("rst_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_illegal", {31'd0, id_ex_illegal}, 32'd0);
      chk("rst_ir", id_ex_ir, 32'd0);
      chk("rst_npc", id_ex_npc, 32'd0);
      chk("rst_a", id_ex_a, 32'd0);
      chk("rst_b", id_ex_b, 32'd0);
      chk("rst_imm", id_ex_imm, 32'd0);
      chk("rst_type", {29'd0, id_ex_type}, 32'd0);
      chk("rst_ready", {31'd0, if_id_ready}, 32'd1);
      @(posedge clk1); #1;
      rst = 1'b0; id_ex_ready = 1'b1;

      issue(mk(32'h2801_0005, 32'd1, 32'd0, 32'd0, 32'h0000_0005, 3'b001, 1'b0), 1'b1);
      wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h1111_1111;
      @(posedge clk1); #1;
      wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
      issue(mk(32'h0064_2800, 32'd2, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_2800, 3'b000, 1'b0), 1'b1);
      wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      @(posedge clk1); #1;
      issue(mk(32'h0C07_3000, 32'd3, 32'd0, 32'd0, 32'h0000_3000, 3'b000, 1'b0), 1'b1);
      wb_we = 1'b0;
      issue(mk(32'h2C62_8000, 32'd4, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_8000, 3'b001, 1'b0), 1'b1);
      issue(mk(32'h2464_FFFC, 32'd5, 32'hDEAD_BEEF, 32'h1111_1111, 32'hFFFF_FFFC, 3'b011, 1'b0), 1'b1);
      issue(mk(32'h3880_0010, 32'd6, 32'h1111_1111, 32'd0, 32'h0000_0010, 3'b100, 1'b0), 1'b1);
      issue(mk(32'hE800_0000, 32'd7, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1), 1'b1);

      // Backpressure with a write-back to the held entry's source register.
      issue(mk(32'h2088_0004, 32'd8, 32'h1111_1111, 32'd0, 32'h0000_0004, 3'b010, 1'b0), 1'b1);
      id_ex_ready = 1'b0;
      if_id_valid = 1'b1; if_id_ir = 32'h3480_0020; if_id_npc = 32'd9;
      wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h2222_2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk1);
         chk("stall_ready", {31'd0, if_id_ready}, 32'd0);
         chk("stall_valid", {31'd0, id_ex_valid}, 32'd1);
         chk("stall_ir", id_ex_ir, 32'h2088_0004);
         chk("stall_a", id_ex_a, 32'h1111_1111);
         @(posedge clk1); #1;
         wb_we = 1'b0;
      end
      id_ex_ready = 1'b1;
      issue(mk(32'h3480_0020, 32'd9, 32'h2222_2222, 32'd0, 32'h0000_0020, 3'b100, 1'b0), 1'b1);

      // Flush a held entry, then flush an acceptable incoming instruction.
      issue(mk(32'h2801_0005, 32'd10, 32'd0, 32'd0, 32'h0000_0005, 3'b001, 1'b0), 1'b0);
      id_ex_ready = 1'b0;
      if_id_valid = 1'b1; if_id_ir = 32'h0064_2800; if_id_npc = 32'd11; flush = 1'b1;
      @(posedge clk1); #1;
      id_ex_ready = 1'b1;
      @(negedge clk1);
      chk("flush_held_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("flush_ready_indep", {31'd0, if_id_ready}, 32'd1);
      @(posedge clk1); #1;
      flush = 1'b0; if_id_valid = 1'b0;
      @(negedge clk1);
      chk("flush_in_valid", {31'd0, id_ex_valid}, 32'd0);
      @(posedge clk1); #1;
      issue(mk(32'h0064_2800, 32'd11, 32'hDEAD_BEEF, 32'h2222_2222, 32'h0000_2800, 3'b000, 1'b0), 1'b1);

      // HLT coinciding with flush is dropped; the next HLT latches.
      if_id_valid = 1'b1; if_id_ir = 32'hFC00_0000; if_id_npc = 32'd12; flush = 1'b1;
      @(posedge clk1); #1;
      flush = 1'b0; if_id_valid = 1'b0;
      @(negedge clk1);
      chk("hlt_flushed_halted", {31'd0, halted}, 32'd0);
      chk("hlt_flushed_valid", {31'd0, id_ex_valid}, 32'd0);
      @(posedge clk1); #1;
      issue(mk(32'hFC00_0000, 32'd13, 32'd0, 32'd0, 32'd0, 3'b101, 1'b0), 1'b1);
      if_id_valid = 1'b1; if_id_ir = 32'h2801_0005; if_id_npc = 32'd14;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk1);
         chk("halt_flag", {31'd0, halted}, 32'd1);
         chk("halt_ready", {31'd0, if_id_ready}, 32'd0);
         @(posedge clk1); #1;
         flush = (i == 1);
      end
      flush = 1'b0;
      @(negedge clk1);
      chk("halt_drained", {31'd0, id_ex_valid}, 32'd0);
      chk("halt_vs_flush", {31'd0, halted}, 32'd1);
      @(posedge clk1); #1;
      if_id_valid = 1'b0;

      rst = 1'b1;
      @(posedge clk1); #1;
      rst = 1'b0;
      @(negedge clk1);
      chk("rst2_halted", {31'd0, halted}, 32'd0);
      chk("rst2_ready", {31'd0, if_id_ready}, 32'd1);
      @(posedge clk1); #1;
      issue(mk(32'h0064_2800, 32'd15, 32'd0, 32'd0, 32'h0000_2800, 3'b000, 1'b0), 1'b1);

      repeat (3) @(posedge clk1);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      chk("pop_count", n_pop, n_push);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
